// File: rtl/enemy_stomp_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_stomp_scheduler
//
// Purpose:
//   Collects per-frame collisions between the player sprite and N enemy
//   head-up boxes. A box is an enemy's drawingRequest-only bracket above its
//   head. At each frame boundary the collected hits are merged into a pending
//   set. The pending hits are then served one at a time, in round-robin order,
//   to the game-logic kill path. The block also keeps the saturating score and
//   produces the player's bounce pulse when a batch of served stomps finishes.
//
// Optional feature macro: STOMP_COMBO_EN
//   defined   : the k-th stomp served in one batch scores
//               POINTS_PER_STOMP << min(k-1,3)
//   undefined : every served stomp scores POINTS_PER_STOMP
//
// Ports:
//   clk            in   1                  system clock
//   resetN         in   1                  asynchronous active-low reset
//   startOfFrame   in   1                  1-cycle pulse at frame start
//   headDrawReq    in   N_ENEMIES          head-box drawingRequest per enemy
//   playerDrawReq  in   1                  player sprite drawingRequest
//   playerFalling  in   1                  player moving down
//   stompAck       in   1                  game logic accepted current stomp
//   stompReq       out  1                  stomp request valid
//   stompIdx       out  clog2(N_ENEMIES)   enemy index of current request
//   bouncePulse    out  1                  batch done with >=1 served stomp
//   timeoutErr     out  1                  request dropped on ack timeout
//   score          out  16                 accumulated score, saturating
// -----------------------------------------------------------------------------
module enemy_stomp_scheduler #(
  parameter int N_ENEMIES        = 4,
  parameter int POINTS_PER_STOMP = 10,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic [N_ENEMIES-1:0]         headDrawReq,
  input  logic                         playerDrawReq,
  input  logic                         playerFalling,
  input  logic                         stompAck,
  output logic                         stompReq,
  output logic [$clog2(N_ENEMIES)-1:0] stompIdx,
  output logic                         bouncePulse,
  output logic                         timeoutErr,
  output logic [15:0]                  score
);

  localparam int IDX_W = $clog2(N_ENEMIES);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N_ENEMIES-1:0] r_hit_sticky;
  logic [N_ENEMIES-1:0] r_pending;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [3:0]           r_batch_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_stomp_req;
  logic [IDX_W-1:0]     r_stomp_idx;
  logic                 r_bounce;
  logic                 r_timeout;
  logic [15:0]          r_score;

  logic [N_ENEMIES-1:0] w_new_hits;
  logic                 w_sel_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W:0]       w_cand;
  logic                 w_ack_take;
  logic                 w_to_fire;
  logic                 w_serve_done;
  logic                 w_batch_end;
  logic [N_ENEMIES-1:0] w_clear_mask;
  logic [N_ENEMIES-1:0] w_pending_nxt;
  logic [N_ENEMIES-1:0] w_hit_sticky_nxt;
  logic [IDX_W-1:0]     w_rr_nxt;
  logic [16:0]          w_points;
  logic [16:0]          w_score_sum;
  logic [15:0]          w_score_nxt;
  logic [1:0]           w_combo_shift;

  // A stomp only counts while the player is moving down onto the head box.
  assign w_new_hits = headDrawReq & {N_ENEMIES{playerDrawReq & playerFalling}};

  // Round-robin pick: first pending bit at or after r_rr_ptr, wrapping.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = {IDX_W{1'b0}};
    w_cand      = {(IDX_W+1){1'b0}};
    for (int k = 0; k < N_ENEMIES; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N_ENEMIES)) begin
        w_cand = w_cand - (IDX_W+1)'(N_ENEMIES);
      end else begin
        w_cand = w_cand;
      end
      if (!w_sel_found && r_pending[w_cand[IDX_W-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand[IDX_W-1:0];
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Next-state and per-state decisions; ack has priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    w_to_fire   = 1'b0;
    w_batch_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_state_nxt = S_SELECT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        if (w_sel_found) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
          w_batch_end = 1'b1;
        end
      end
      S_REQ: begin
        if (stompAck) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_SELECT;
        end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          w_to_fire   = 1'b1;
          w_state_nxt = S_SELECT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_serve_done = w_ack_take | w_to_fire;

  // Pending/capture updates; new hits seen on the frame-boundary cycle belong to the new frame.
  always_comb begin
    w_clear_mask = {N_ENEMIES{1'b0}};
    if (w_serve_done) begin
      w_clear_mask[r_stomp_idx] = 1'b1;
    end else begin
      w_clear_mask = {N_ENEMIES{1'b0}};
    end
    if (startOfFrame) begin
      w_pending_nxt    = (r_pending & ~w_clear_mask) | r_hit_sticky;
      w_hit_sticky_nxt = w_new_hits;
    end else begin
      w_pending_nxt    = r_pending & ~w_clear_mask;
      w_hit_sticky_nxt = r_hit_sticky | w_new_hits;
    end
  end

  // Pointer moves just past the enemy that was served or dropped.
  always_comb begin
    if (r_stomp_idx == IDX_W'(N_ENEMIES - 1)) begin
      w_rr_nxt = {IDX_W{1'b0}};
    end else begin
      w_rr_nxt = r_stomp_idx + IDX_W'(1);
    end
  end

  // Points for the stomp being acked, then saturating score add.
  always_comb begin
`ifdef STOMP_COMBO_EN
    if (r_batch_cnt > 4'd3) begin
      w_combo_shift = 2'd3;
    end else begin
      w_combo_shift = r_batch_cnt[1:0];
    end
`else
    w_combo_shift = 2'd0;
`endif
    w_points    = 17'(POINTS_PER_STOMP) << w_combo_shift;
    w_score_sum = {1'b0, r_score} + w_points;
    if (w_score_sum[16]) begin
      w_score_nxt = 16'hFFFF;
    end else begin
      w_score_nxt = w_score_sum[15:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture, pending, pointer, batch and timeout bookkeeping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_sticky <= {N_ENEMIES{1'b0}};
      r_pending    <= {N_ENEMIES{1'b0}};
      r_rr_ptr     <= {IDX_W{1'b0}};
      r_batch_cnt  <= 4'd0;
      r_to_cnt     <= {TO_W{1'b0}};
    end else begin
      r_hit_sticky <= w_hit_sticky_nxt;
      r_pending    <= w_pending_nxt;
      if (w_serve_done) begin
        r_rr_ptr <= w_rr_nxt;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      // A new frame resets the batch only when no batch is in flight.
      if (w_batch_end) begin
        r_batch_cnt <= 4'd0;
      end else if (startOfFrame && (r_state == S_IDLE)) begin
        r_batch_cnt <= 4'd0;
      end else if (w_ack_take && (r_batch_cnt != 4'd15)) begin
        r_batch_cnt <= r_batch_cnt + 4'd1;
      end else begin
        r_batch_cnt <= r_batch_cnt;
      end
      // Counts REQ cycles; restarts at zero on every entry to REQ.
      if ((r_state == S_REQ) && (w_state_nxt == S_REQ)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= {TO_W{1'b0}};
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_stomp_req <= 1'b0;
      r_stomp_idx <= {IDX_W{1'b0}};
      r_bounce    <= 1'b0;
      r_timeout   <= 1'b0;
      r_score     <= 16'd0;
    end else begin
      r_stomp_req <= (w_state_nxt == S_REQ);
      if ((r_state == S_SELECT) && w_sel_found) begin
        r_stomp_idx <= w_sel_idx;
      end else begin
        r_stomp_idx <= r_stomp_idx;
      end
      r_bounce  <= w_batch_end && (r_batch_cnt != 4'd0);
      r_timeout <= w_to_fire;
      if (w_ack_take) begin
        r_score <= w_score_nxt;
      end else begin
        r_score <= r_score;
      end
    end
  end

  assign stompReq    = r_stomp_req;
  assign stompIdx    = r_stomp_idx;
  assign bouncePulse = r_bounce;
  assign timeoutErr  = r_timeout;
  assign score       = r_score;

endmodule

// File: tb/tb_enemy_stomp_scheduler.sv
// Directed bench for enemy_stomp_scheduler with hand-computed expectations.
module tb_enemy_stomp_scheduler;

  localparam int N = 4;

  logic         clk;
  logic         resetN;
  logic         startOfFrame;
  logic [N-1:0] headDrawReq;
  logic         playerDrawReq;
  logic         playerFalling;
  logic         stompAck;
  logic         stompReq;
  logic [1:0]   stompIdx;
  logic         bouncePulse;
  logic         timeoutErr;
  logic [15:0]  score;

  int n_vec = 0;
  int n_err = 0;
  int exp_score = 0;
  int bounce_cnt = 0;
  int timeout_cnt = 0;

  enemy_stomp_scheduler #(
    .N_ENEMIES(4),
    .POINTS_PER_STOMP(10),
    .ACK_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .headDrawReq(headDrawReq),
    .playerDrawReq(playerDrawReq),
    .playerFalling(playerFalling),
    .stompAck(stompAck),
    .stompReq(stompReq),
    .stompIdx(stompIdx),
    .bouncePulse(bouncePulse),
    .timeoutErr(timeoutErr),
    .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bouncePulse === 1'b1) bounce_cnt <= bounce_cnt + 1;
    if (timeoutErr === 1'b1) timeout_cnt <= timeout_cnt + 1;
  end

  // Points of the k-th (0-based) stomp within one batch.
  function automatic int pts(input int k);
`ifdef STOMP_COMBO_EN
    return 10 << ((k > 3) ? 3 : k);
`else
    return 10;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_hit(input logic [N-1:0] m);
    headDrawReq = m; playerDrawReq = 1'b1; playerFalling = 1'b1;
    tick();
    headDrawReq = '0; playerDrawReq = 1'b0; playerFalling = 1'b0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stompReq === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // One single-hit batch on enemy e with an immediate ack.
  task automatic serve_one(input int e, output bit ok);
    logic [N-1:0] m;
    bit seen;
    m = '0;
    m[e] = 1'b1;
    apply_hit(m);
    sof();
    wait_req(seen);
    ok = seen && (stompIdx == 2'(e));
    stompAck = 1'b1;
    tick();
    stompAck = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 1'b0; headDrawReq = '0;
    playerDrawReq = 1'b0; playerFalling = 1'b0; stompAck = 1'b0;
    #12;
    n_vec++;
    if ({stompReq, stompIdx, bouncePulse, timeoutErr} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {stompReq, stompIdx, bouncePulse, timeoutErr});
    end
    n_vec++;
    if (score !== 16'd0) begin
      n_err++; $display("FAIL reset_score: got %h expected 0000", score);
    end
    @(negedge clk);
    resetN = 1'b1;
    tick();
    tick();
    n_vec++;
    if (stompReq !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_req: got %b expected 0", stompReq);
    end
  endtask

  task automatic test_single_stomp();
    int b0;
    b0 = bounce_cnt;
    apply_hit(4'b0100);
    tick();
    sof();
    n_vec++;
    if (stompReq !== 1'b0) begin
      n_err++; $display("FAIL t1_req_sof1: got %b expected 0", stompReq);
    end
    tick();
    n_vec++;
    if (stompReq !== 1'b0) begin
      n_err++; $display("FAIL t1_req_sof2: got %b expected 0", stompReq);
    end
    tick();
    n_vec++;
    if (stompReq !== 1'b1 || stompIdx !== 2'd2) begin
      n_err++; $display("FAIL t1_req_sof3: got req=%b idx=%0d expected req=1 idx=2", stompReq, stompIdx);
    end
    tick();
    tick();
    stompAck = 1'b1;
    tick();
    stompAck = 1'b0;
    exp_score += pts(0);
    n_vec++;
    if (stompReq !== 1'b0 || score !== 16'(exp_score)) begin
      n_err++; $display("FAIL t1_after_ack: got req=%b score=%0d expected req=0 score=%0d", stompReq, score, exp_score);
    end
    n_vec++;
    if (bouncePulse !== 1'b0) begin
      n_err++; $display("FAIL t1_bounce_early: got %b expected 0", bouncePulse);
    end
    tick();
    n_vec++;
    if (bouncePulse !== 1'b1) begin
      n_err++; $display("FAIL t1_bounce: got %b expected 1", bouncePulse);
    end
    tick();
    tick();
    n_vec++;
    if (bounce_cnt - b0 !== 1) begin
      n_err++; $display("FAIL t1_bounce_count: got %0d expected 1", bounce_cnt - b0);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    bit seen;
    int b0;
    int exp_order [3];
    exp_order = '{3, 0, 1};
    // Serving enemy 1 leaves the pointer at 2.
    serve_one(1, ok);
    exp_score += pts(0);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL t2_prep: got ok=%b expected ok=1", ok);
    end
    tick();
    b0 = bounce_cnt;
    apply_hit(4'b1011);
    sof();
    wait_req(seen);
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (stompReq !== 1'b1 || stompIdx !== 2'(exp_order[j])) begin
        n_err++; $display("FAIL t2_order%0d: got req=%b idx=%0d expected req=1 idx=%0d", j, stompReq, stompIdx, exp_order[j]);
      end
      stompAck = 1'b1;
      tick();
      stompAck = 1'b0;
      exp_score += pts(j);
      tick();
    end
    tick();
    tick();
    tick();
    n_vec++;
    if (score !== 16'(exp_score)) begin
      n_err++; $display("FAIL t2_score: got %0d expected %0d", score, exp_score);
    end
    n_vec++;
    if (bounce_cnt - b0 !== 1) begin
      n_err++; $display("FAIL t2_bounce_count: got %0d expected 1", bounce_cnt - b0);
    end
  endtask

  task automatic test_not_falling();
    int req_seen;
    req_seen = 0;
    headDrawReq = 4'b1111; playerDrawReq = 1'b1; playerFalling = 1'b0;
    tick(); tick();
    headDrawReq = 4'b1111; playerDrawReq = 1'b0; playerFalling = 1'b1;
    tick();
    headDrawReq = '0; playerFalling = 1'b0;
    sof();
    // A stray ack while idle must be ignored.
    stompAck = 1'b1;
    tick();
    stompAck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (stompReq === 1'b1) req_seen++;
      tick();
    end
    n_vec++;
    if (req_seen !== 0) begin
      n_err++; $display("FAIL t3_no_req: got %0d req cycles expected 0", req_seen);
    end
    n_vec++;
    if (score !== 16'(exp_score)) begin
      n_err++; $display("FAIL t3_score: got %0d expected %0d", score, exp_score);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int req_cycles;
    int b0;
    int t0;
    int late_req;
    b0 = bounce_cnt;
    t0 = timeout_cnt;
    apply_hit(4'b0010);
    sof();
    wait_req(seen);
    n_vec++;
    if (!seen || stompIdx !== 2'd1) begin
      n_err++; $display("FAIL t4_req: got seen=%b idx=%0d expected seen=1 idx=1", seen, stompIdx);
    end
    req_cycles = seen ? 1 : 0;
    for (int i = 0; i < 400 && seen; i++) begin
      tick();
      if (stompReq === 1'b1) req_cycles++;
      else break;
    end
    n_vec++;
    if (req_cycles !== 255) begin
      n_err++; $display("FAIL t4_req_cycles: got %0d expected 255", req_cycles);
    end
    n_vec++;
    if (timeoutErr !== 1'b1) begin
      n_err++; $display("FAIL t4_timeout_pulse: got %b expected 1", timeoutErr);
    end
    tick();
    n_vec++;
    if (timeoutErr !== 1'b0) begin
      n_err++; $display("FAIL t4_timeout_width: got %b expected 0", timeoutErr);
    end
    late_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (stompReq === 1'b1) late_req++;
      tick();
    end
    n_vec++;
    if (late_req !== 0 || score !== 16'(exp_score)) begin
      n_err++; $display("FAIL t4_after: got req_cycles=%0d score=%0d expected 0 and %0d", late_req, score, exp_score);
    end
    n_vec++;
    if (bounce_cnt - b0 !== 0 || timeout_cnt - t0 !== 1) begin
      n_err++; $display("FAIL t4_pulses: got bounce=%0d timeout=%0d expected 0 and 1", bounce_cnt - b0, timeout_cnt - t0);
    end
  endtask

  task automatic test_merge();
    bit seen;
    int b0;
    int late_req;
    int exp_order [3];
    exp_order = '{2, 3, 0};
    b0 = bounce_cnt;
    // Pointer is 2 here; enemies 0 and 2 hit.
    apply_hit(4'b0101);
    sof();
    wait_req(seen);
    // Re-hit enemy 0 (still pending) and new hit on 3 during REQ, then a new frame.
    apply_hit(4'b1001);
    tick();
    sof();
    n_vec++;
    if (stompReq !== 1'b1 || stompIdx !== 2'd2) begin
      n_err++; $display("FAIL t5_held: got req=%b idx=%0d expected req=1 idx=2", stompReq, stompIdx);
    end
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (stompReq !== 1'b1 || stompIdx !== 2'(exp_order[j])) begin
        n_err++; $display("FAIL t5_order%0d: got req=%b idx=%0d expected req=1 idx=%0d", j, stompReq, stompIdx, exp_order[j]);
      end
      stompAck = 1'b1;
      tick();
      stompAck = 1'b0;
      exp_score += pts(j);
      tick();
    end
    late_req = 0;
    for (int i = 0; i < 8; i++) begin
      if (stompReq === 1'b1) late_req++;
      tick();
    end
    n_vec++;
    if (late_req !== 0) begin
      n_err++; $display("FAIL t5_no_dup: got %0d extra req cycles expected 0", late_req);
    end
    n_vec++;
    if (score !== 16'(exp_score) || bounce_cnt - b0 !== 1) begin
      n_err++; $display("FAIL t5_score_bounce: got score=%0d bounce=%0d expected %0d and 1", score, bounce_cnt - b0, exp_score);
    end
  endtask

  task automatic test_saturation_and_reset();
    bit ok;
    bit all_ok;
    bit seen;
    int cnt;
    int late_req;
    all_ok = 1'b1;
    cnt = 0;
    while (exp_score < 65526) begin
      serve_one(cnt % N, ok);
      all_ok = all_ok & ok;
      exp_score += 10;
      cnt++;
    end
    n_vec++;
    if (!all_ok || score !== 16'hFFFA) begin
      n_err++; $display("FAIL t6_preset: got ok=%b score=%h expected ok=1 score=fffa", all_ok, score);
    end
    serve_one(1, ok);
    n_vec++;
    if (score !== 16'hFFFF) begin
      n_err++; $display("FAIL t6_saturate: got %h expected ffff", score);
    end
    serve_one(2, ok);
    n_vec++;
    if (score !== 16'hFFFF) begin
      n_err++; $display("FAIL t6_hold_sat: got %h expected ffff", score);
    end
    // Reset in the middle of a request.
    apply_hit(4'b1000);
    sof();
    wait_req(seen);
    #2;
    resetN = 1'b0;
    #1;
    n_vec++;
    if ({stompReq, stompIdx, bouncePulse, timeoutErr} !== 5'b0 || score !== 16'd0) begin
      n_err++; $display("FAIL t6_async_reset: got ctrl=%b score=%h expected ctrl=00000 score=0000",
                        {stompReq, stompIdx, bouncePulse, timeoutErr}, score);
    end
    tick();
    tick();
    resetN = 1'b1;
    exp_score = 0;
    late_req = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (stompReq === 1'b1) late_req++;
    end
    n_vec++;
    if (late_req !== 0 || score !== 16'd0) begin
      n_err++; $display("FAIL t6_post_reset: got req_cycles=%0d score=%0d expected 0 and 0", late_req, score);
    end
  endtask

  initial begin
    test_reset();
    test_single_stomp();
    test_round_robin();
    test_not_falling();
    test_timeout();
    test_merge();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
